equiv_check_sequencer: RTL
==========================

Name: equiv_check_sequencer

Overview:
- Self-checking controller that exhaustively drives a shared input bus into a test module and a ground-truth module.
- Delays each vector's expectation by the modules' pipeline depth, compares their outputs and accumulates pass/fail results.
- Provides the hardware equivalent of the exhaustive Verilator comparison flow, so equivalence can be checked on-fabric or in long sims without a software testbench.
- Sits between the two instantiated modules and a host/status interface.

Parameters:
- IN_WIDTH, 2, total concatenated input bits to both modules; test cases = 2^IN_WIDTH (1..16).
- OUT_WIDTH, 1, concatenated output bits compared.
- PIPELINE_DEPTH, 0, cycles from stimulus to valid output (0 = combinational, 0..16).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- stim  output  IN_WIDTH  registered vector driven to both modules.
- test_out  input  OUT_WIDTH  test module outputs.
- gt_out  input  OUT_WIDTH  ground-truth outputs.
- busy  output  1  high in DRIVE and DRAIN.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid with done; 1 iff mismatch_count == 0.
- mismatch_count  output  IN_WIDTH+1  number of failing vectors.
- first_fail_valid  output  1  at least one mismatch recorded this run.
- first_fail_vec  output  IN_WIDTH  stimulus of the earliest mismatch.

Behaviour:
- Reset (async assert, synchronous release), all outputs 0:
  - state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_valid=0, first_fail_vec=0.
  - Tag pipeline cleared.
  - Reset mid-run aborts immediately; no partial result is retained.
- States:
  - IDLE: start=1 at edge E → DRIVE, stim=0. Clears mismatch_count, first_fail_*, done and pass.
  - DRIVE: stim increments by 1 each edge. The edge at which stim==2^IN_WIDTH-1 is held:
    - goes to DRAIN if PIPELINE_DEPTH>0, loading drain counter = PIPELINE_DEPTH-1;
    - goes to DONE if PIPELINE_DEPTH==0.
    - stim wraps to 0 on that edge and holds 0 thereafter.
  - DRAIN: counter decrements each edge; at 0 → DONE.
  - DONE: done=1, pass valid. start=1 behaves as from IDLE (restart, counters cleared).
- start is ignored while busy.
- Timing: done rises 2^IN_WIDTH + PIPELINE_DEPTH edges after edge E.
- Tag pipeline: shift register PIPELINE_DEPTH deep carrying {valid, vector}.
  - Entry valid=1 while in DRIVE; bubbles valid=0 otherwise.
  - Tap = pipeline output, or for PIPELINE_DEPTH=0 the current {DRIVE, stim}.
- Compare, on each edge where tap valid=1:
  - mismatch iff test_out != gt_out (bitwise, all OUT_WIDTH bits).
  - On mismatch: mismatch_count += 1 (cannot overflow; max 2^IN_WIDTH).
  - If first_fail_valid==0: first_fail_vec = tap vector, first_fail_valid = 1.
  - Exactly 2^IN_WIDTH compares per run; the last compare occurs on the edge entering DONE.
- pass = done & (mismatch_count==0), registered with the DONE transition.
- X on test_out/gt_out is not masked; the bench must not present X on valid compare cycles.

Test Plan:
- IN_WIDTH=2, OUT_WIDTH=1, DEPTH=0, test = a&b, gt = ~(~a|~b); pulse start → stim 0,1,2,3 on consecutive cycles; done 4 edges later; pass=1; mismatch_count=0; first_fail_valid=0.
- Same config, test = a^b, gt = a&b → mismatches at vectors 1,2,3; mismatch_count=3, first_fail_vec=2'b01, pass=0.
- IN_WIDTH=3, DEPTH=2, both modules registered twice, identical logic → done 10 edges after start; pass=1. Then make the test output stuck-at-0 at vector 5 only → count=1, first_fail_vec=3'd5, confirming alignment (off-by-one delay would flag different vectors).
- Pulse start again 3 cycles into DRIVE → ignored; stim sequence and done timing unchanged.
- Assert rst_n=0 mid-DRAIN → all outputs 0 immediately and asynchronously; after release, state IDLE, no done; new start gives a full correct run.
- From DONE with a failing result, pulse start with matching modules → counters cleared on that edge; final pass=1, count=0.

Source files
------------

// File: rtl/equiv_check_sequencer.sv
// Exhaustive equivalence sequencer: sweeps every input vector into a test and a ground-truth module.
// It compares their outputs after the pipeline latency and reports the mismatch count and the first failing vector.
module equiv_check_sequencer #(
    parameter int IN_WIDTH       = 2,
    parameter int OUT_WIDTH      = 1,
    parameter int PIPELINE_DEPTH = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [IN_WIDTH-1:0]  stim,
    input  logic [OUT_WIDTH-1:0] test_out,
    input  logic [OUT_WIDTH-1:0] gt_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [IN_WIDTH:0]    mismatch_count,
    output logic                 first_fail_valid,
    output logic [IN_WIDTH-1:0]  first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                  DRAIN_W    = 5;
    localparam logic [IN_WIDTH-1:0] LAST_VEC   = '1;
    localparam logic [DRAIN_W-1:0]  DRAIN_LOAD =
        (PIPELINE_DEPTH > 0) ? DRAIN_W'(PIPELINE_DEPTH - 1) : '0;

    state_t               state;
    state_t               state_next;
    logic                 launch;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [IN_WIDTH:0]    tap;
    logic                 tap_valid;
    logic [IN_WIDTH-1:0]  tap_vec;
    logic                 mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_DRIVE;
                    launch     = 1'b1;
                end
            end
            S_DRIVE: begin
                if (stim == LAST_VEC) begin
                    state_next = (PIPELINE_DEPTH > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Each vector travels alongside the modules' latency so the compare knows which vector it is judging.
    generate
        if (PIPELINE_DEPTH > 0) begin : g_tag_pipe
            logic [IN_WIDTH:0] pipe [PIPELINE_DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPELINE_DEPTH; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= {state == S_DRIVE, stim};
                    for (int i = 1; i < PIPELINE_DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tap = pipe[PIPELINE_DEPTH-1];
        end else begin : g_tag_direct
            assign tap = {state == S_DRIVE, stim};
        end
    endgenerate

    assign tap_valid = tap[IN_WIDTH];
    assign tap_vec   = tap[IN_WIDTH-1:0];
    assign mismatch  = (test_out != gt_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim             <= '0;
            drain_cnt        <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (launch) begin
            stim             <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            // Incrementing past the last vector wraps stim back to 0, where it stays once DRIVE ends.
            if (state == S_DRIVE) begin
                stim <= stim + 1'b1;
            end
            if (state == S_DRIVE && stim == LAST_VEC) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (tap_valid && mismatch) begin
                mismatch_count <= mismatch_count + 1'b1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= tap_vec;
                end
            end
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && (mismatch_count == '0);

endmodule
